// File: rtl/ddr_traffic_checker.sv
// DDR host-interface traffic generator/checker: writes NUM_WORDS patterned words, reads them back, compares.
// Latency: start->first req_valid 1 cycle; per word >=2 cycles (write), >=3 cycles + controller latency (read).
// Backpressure: req_valid/req_addr/req_wdata held until req_ack; one read outstanding, bounded by TIMEOUT.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, mode, seed        run request; mode/seed latched when start is accepted in IDLE
//   busy, done, pass         run status; done/pass held until the next accepted start
//   err_count, timeout_seen  saturating error count, sticky read-timeout flag
//   first_err_addr/_data     address and read data of the first error (data 0 on timeout)
//   req_*, resp_*            DDR controller host interface
// Optional: define DDR_TRAFFIC_ERR_INJECT_EN to add input err_inject (latched at start), which
// inverts bit 0 of word 0's write data while leaving the expected read value untouched.
module ddr_traffic_checker #(
    parameter int                ADDR_W      = 25,
    parameter int                DATA_W      = 16,
    parameter int                NUM_WORDS   = 16,
    parameter int                BASE_ADDR   = 0,
    parameter int                ADDR_STRIDE = 1,
    parameter int                TIMEOUT     = 1024,
    parameter logic [DATA_W-1:0] LFSR_TAPS   = DATA_W'(16'hB400)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic              timeout_seen,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data,
    output logic              req_valid,
    output logic              req_rw,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_wdata,
    input  logic              req_ack,
    input  logic              resp_valid,
    input  logic [DATA_W-1:0] resp_rdata
`ifdef DDR_TRAFFIC_ERR_INJECT_EN
    ,
    input  logic              err_inject
`endif
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(ADDR_STRIDE);

    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_GAP, RD_REQ, RD_WAIT, RD_GAP, DONE
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] pat_q, pat_d;      // pattern value of the current word
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [15:0]       err_count_q, err_count_d;
    logic              timeout_seen_q, timeout_seen_d;
    logic [ADDR_W-1:0] first_err_addr_q, first_err_addr_d;
    logic [DATA_W-1:0] first_err_data_q, first_err_data_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              inj_q, inj_d;

    logic              inj_in;
    logic [ADDR_W-1:0] addr_nxt;
    logic              err_hit;
    logic [DATA_W-1:0] err_dat;

`ifdef DDR_TRAFFIC_ERR_INJECT_EN
    assign inj_in = err_inject;
`else
    assign inj_in = 1'b0;
`endif

    // Address arithmetic wraps modulo 2^ADDR_W by construction.
    assign addr_nxt = addr_q + STRIDE_A;

    // Pattern value for word 0. Mode 3 uses the base address directly.
    function automatic logic [DATA_W-1:0] pat_first(input logic [1:0]        m,
                                                    input logic [DATA_W-1:0] s);
        logic [DATA_W-1:0] r;
        case (m)
            2'd0:    r = s;
            2'd1:    r = DATA_W'(1);
            2'd2:    r = (s == '0) ? DATA_W'(1) : s;  // all-zero LFSR would lock up
            default: r = DATA_W'(BASE_A) ^ s;
        endcase
        return r;
    endfunction

    // Pattern value for word i+1 given word i. Walking-ones as a rotate gives 1 << (i mod DATA_W).
    function automatic logic [DATA_W-1:0] pat_step(input logic [1:0]        m,
                                                   input logic [DATA_W-1:0] s,
                                                   input logic [DATA_W-1:0] cur,
                                                   input logic [ADDR_W-1:0] nxt_addr);
        logic [DATA_W-1:0] r;
        case (m)
            2'd0:    r = cur + DATA_W'(1);
            2'd1:    r = {cur[DATA_W-2:0], cur[DATA_W-1]};
            2'd2:    r = (cur >> 1) ^ (cur[0] ? LFSR_TAPS : '0);
            default: r = DATA_W'(nxt_addr) ^ s;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        addr_d           = addr_q;
        pat_d            = pat_q;
        mode_d           = mode_q;
        seed_d           = seed_q;
        tmo_d            = tmo_q;
        err_count_d      = err_count_q;
        timeout_seen_d   = timeout_seen_q;
        first_err_addr_d = first_err_addr_q;
        first_err_data_d = first_err_data_q;
        done_d           = done_q;
        pass_d           = pass_q;
        inj_d            = inj_q;
        err_hit          = 1'b0;
        err_dat          = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d           = mode;
                    seed_d           = seed;
                    inj_d            = inj_in;
                    idx_d            = '0;
                    addr_d           = BASE_A;
                    pat_d            = pat_first(mode, seed);
                    err_count_d      = '0;
                    timeout_seen_d   = 1'b0;
                    first_err_addr_d = '0;
                    first_err_data_d = '0;
                    done_d           = 1'b0;
                    pass_d           = 1'b0;
                    state_d          = WR_REQ;
                end
            end
            WR_REQ: begin
                if (req_ack) state_d = WR_GAP;
            end
            // The gap cycle drops req_valid so a level-held ack cannot be taken twice.
            WR_GAP: begin
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    addr_d  = BASE_A;
                    pat_d   = pat_first(mode_q, seed_q);  // regenerate expected data
                    state_d = RD_REQ;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    addr_d  = addr_nxt;
                    pat_d   = pat_step(mode_q, seed_q, pat_q, addr_nxt);
                    state_d = WR_REQ;
                end
            end
            RD_REQ: begin
                if (req_ack) begin
                    tmo_d   = '0;
                    state_d = RD_WAIT;
                end
            end
            // A response in the expiry cycle wins over the timeout.
            RD_WAIT: begin
                if (resp_valid) begin
                    if (resp_rdata != pat_q) begin
                        err_hit = 1'b1;
                        err_dat = resp_rdata;
                    end
                    state_d = RD_GAP;
                end else if (tmo_q == TMO_LAST) begin
                    err_hit        = 1'b1;
                    timeout_seen_d = 1'b1;
                    state_d        = RD_GAP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            RD_GAP: begin
                if (idx_q == LAST_IDX) begin
                    done_d  = 1'b1;
                    pass_d  = (err_count_q == '0);
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    addr_d  = addr_nxt;
                    pat_d   = pat_step(mode_q, seed_q, pat_q, addr_nxt);
                    state_d = RD_REQ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // err_count never wraps, so zero reliably means "no error recorded yet".
        if (err_hit) begin
            if (err_count_q == '0) begin
                first_err_addr_d = addr_q;
                first_err_data_d = err_dat;
            end
            if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            idx_q            <= '0;
            addr_q           <= '0;
            pat_q            <= '0;
            mode_q           <= '0;
            seed_q           <= '0;
            tmo_q            <= '0;
            err_count_q      <= '0;
            timeout_seen_q   <= 1'b0;
            first_err_addr_q <= '0;
            first_err_data_q <= '0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            inj_q            <= 1'b0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            addr_q           <= addr_d;
            pat_q            <= pat_d;
            mode_q           <= mode_d;
            seed_q           <= seed_d;
            tmo_q            <= tmo_d;
            err_count_q      <= err_count_d;
            timeout_seen_q   <= timeout_seen_d;
            first_err_addr_q <= first_err_addr_d;
            first_err_data_q <= first_err_data_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
            inj_q            <= inj_d;
        end
    end

    assign busy = (state_q == WR_REQ) || (state_q == WR_GAP) || (state_q == RD_REQ) ||
                  (state_q == RD_WAIT) || (state_q == RD_GAP);

    assign req_valid = (state_q == WR_REQ) || (state_q == RD_REQ);
    assign req_rw    = (state_q == RD_REQ);
    // Request fields read as zero while idle so every output is 0 straight after reset.
    assign req_addr  = req_valid ? addr_q : '0;
    assign req_wdata = (state_q == WR_REQ) ?
                       (pat_q ^ {{(DATA_W-1){1'b0}}, inj_q && (idx_q == '0)}) : '0;

    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_count_q;
    assign timeout_seen   = timeout_seen_q;
    assign first_err_addr = first_err_addr_q;
    assign first_err_data = first_err_data_q;

endmodule

// File: tb/tb_ddr_traffic_checker.sv
// Scoreboard bench for ddr_traffic_checker against a behavioural memory model.
// Latency: memory acks 2 cycles after req_valid, returns read data 5 cycles after read ack.
// Backpressure: the memory model alone paces the DUT through req_ack / resp_valid.
module tb_ddr_traffic_checker;

    localparam int AW     = 25;
    localparam int DW     = 16;
    localparam int NW     = 20;
    localparam int TMO    = 40;
    localparam int BASE   = 0;
    localparam int STRIDE = 1;
    localparam logic [DW-1:0] TAPS = 16'hB400;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    typedef struct {
        bit            pass;
        int            ec;
        bit            to;
        logic [AW-1:0] fa;
        logic [DW-1:0] fd;
    } res_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [DW-1:0] seed = '0;
    logic          busy, done, pass, timeout_seen;
    logic [15:0]   err_count;
    logic [AW-1:0] first_err_addr, req_addr;
    logic [DW-1:0] first_err_data, req_wdata;
    logic          req_valid, req_rw;
    logic          req_ack = 1'b0;
    logic          resp_valid = 1'b0;
    logic [DW-1:0] resp_rdata = '0;
    logic [103:0]  outs_all;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int flip_addr = -1;
    int withhold_addr = -1;
    bit stray_en = 1'b0;

    logic [DW-1:0] mem [int];
    wr_t           exp_wr [$];
    logic [AW-1:0] exp_rd [$];
    res_t          exp_res [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ddr_traffic_checker #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(NW), .BASE_ADDR(BASE),
        .ADDR_STRIDE(STRIDE), .TIMEOUT(TMO), .LFSR_TAPS(TAPS)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .timeout_seen(timeout_seen), .first_err_addr(first_err_addr),
        .first_err_data(first_err_data), .req_valid(req_valid), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ack(req_ack),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata)
`ifdef DDR_TRAFFIC_ERR_INJECT_EN
        , .err_inject(1'b0)
`endif
    );

    assign outs_all = {busy, done, pass, err_count, timeout_seen, first_err_addr,
                       first_err_data, req_valid, req_rw, req_addr, req_wdata};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: the run's word list and outcome derived directly from the pattern rules.
    task automatic expect_run(input logic [1:0] m, input logic [DW-1:0] s,
                              input int fl, input int wh);
        logic [DW-1:0] lfsr;
        res_t          r;
        wr_t           w;
        lfsr = (s == '0) ? 16'd1 : s;
        r.pass = 1'b1; r.ec = 0; r.to = 1'b0; r.fa = '0; r.fd = '0;
        for (int i = 0; i < NW; i++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            a = AW'(longint'(BASE) + longint'(i) * longint'(STRIDE));
            case (m)
                2'd0: d = s + DW'(i);
                2'd1: d = DW'(1) << (i % DW);
                2'd2: begin
                    d    = lfsr;
                    lfsr = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 16'h0000);
                end
                default: d = a[DW-1:0] ^ s;
            endcase
            w.a = a; w.d = d;
            exp_wr.push_back(w);
            exp_rd.push_back(a);
            if (int'(a) == wh || int'(a) == fl) begin
                if (r.ec == 0) begin
                    r.fa = a;
                    r.fd = (int'(a) == wh) ? 16'h0000 : (d ^ 16'h0008);
                end
                r.ec++;
                if (int'(a) == wh) r.to = 1'b1;
            end
        end
        r.pass = (r.ec == 0);
        exp_res.push_back(r);
    endtask

    // Memory model: stores writes, returns reads (optionally corrupted or withheld).
    initial begin : mem_model
        logic          rw;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        forever begin
            @(posedge clk); #1;
            if (req_valid && !rst) begin
                repeat (2) begin @(posedge clk); #1; end
                if (req_valid && !rst) begin
                    rw = req_rw; a = req_addr; d = req_wdata;
                    req_ack = 1'b1;
                    @(posedge clk); #1;
                    if (!rw) begin
                        mem[int'(a)] = d;
                        // Stray response and a held ack while the DUT is in its write gap.
                        if (stray_en) begin
                            resp_valid = 1'b1; resp_rdata = ~d;
                            @(posedge clk); #1;
                            resp_valid = 1'b0;
                        end
                        req_ack = 1'b0;
                    end else begin
                        req_ack = 1'b0;
                        if (int'(a) != withhold_addr) begin
                            repeat (4) @(posedge clk);
                            #1;
                            resp_valid = 1'b1;
                            resp_rdata = (mem.exists(int'(a)) ? mem[int'(a)] : 16'h0000) ^
                                         ((int'(a) == flip_addr) ? 16'h0008 : 16'h0000);
                            @(posedge clk); #1;
                            resp_valid = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Monitor: compares every accepted request and every run result against the queues.
    initial begin : monitor
        bit   done_prev;
        bit   wh_pend;
        int   t_acc;
        wr_t  w;
        res_t r;
        logic [AW-1:0] ea;
        done_prev = 1'b0; wh_pend = 1'b0; t_acc = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (req_valid && req_ack) begin
                    if (!req_rw) begin
                        if (exp_wr.size() == 0) begin
                            vectors++; miscompares++;
                            $display("FAIL wr_unexpected: write to 0x%0h, no write expected", req_addr);
                        end else begin
                            w = exp_wr.pop_front();
                            chk("wr_addr", 128'(req_addr), 128'(w.a));
                            chk("wr_data", 128'(req_wdata), 128'(w.d));
                        end
                    end else begin
                        if (exp_rd.size() == 0) begin
                            vectors++; miscompares++;
                            $display("FAIL rd_unexpected: read of 0x%0h, no read expected", req_addr);
                        end else begin
                            ea = exp_rd.pop_front();
                            chk("rd_addr", 128'(req_addr), 128'(ea));
                        end
                        if (int'(req_addr) == withhold_addr) begin
                            t_acc = cyc; wh_pend = 1'b1;
                        end
                    end
                end
                // Accept edge + TIMEOUT cycles in RD_WAIT + 1 gap cycle -> next read request.
                if (wh_pend && req_valid && req_rw && int'(req_addr) != withhold_addr) begin
                    chk("timeout_span", 128'(cyc - t_acc), 128'(TMO + 2));
                    wh_pend = 1'b0;
                end
                if (done && !done_prev) begin
                    if (exp_res.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL done_unexpected: done rose, no run expected");
                    end else begin
                        r = exp_res.pop_front();
                        chk("res_busy",      128'(busy), 128'(0));
                        chk("res_pass",      128'(pass), 128'(r.pass));
                        chk("res_err_count", 128'(err_count), 128'(r.ec));
                        chk("res_timeout",   128'(timeout_seen), 128'(r.to));
                        chk("res_first_addr", 128'(first_err_addr), 128'(r.fa));
                        chk("res_first_data", 128'(first_err_data), 128'(r.fd));
                    end
                end
            end
            done_prev = done;
        end
    end

    task automatic run(input logic [1:0] m, input logic [DW-1:0] s, input int fl,
                       input int wh, input bit st, input bit abort);
        int n;
        expect_run(m, s, fl, wh);
        flip_addr = fl; withhold_addr = wh; stray_en = st;
        @(negedge clk);
        mode = m; seed = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0; mode = ~m; seed = ~s;   // must be ignored mid-run
        chk("start_busy",      128'(busy), 128'(1));
        chk("start_req_valid", 128'(req_valid), 128'(1));
        chk("start_req_rw",    128'(req_rw), 128'(0));
        chk("start_done_clr",  128'(done), 128'(0));
        if (abort) begin
            n = 0;
            while (!(exp_wr.size() <= NW - 3 && req_valid && !req_ack) && n < 2000) begin
                @(negedge clk); n++;
            end
            rst = 1'b1;
            @(negedge clk);
            chk("midrun_reset_outputs", 128'(outs_all), 128'(0));
            rst = 1'b0;
            exp_wr.delete(); exp_rd.delete(); exp_res.delete();
            repeat (5) @(negedge clk);
            return;
        end
        repeat (6) @(negedge clk);
        start = 1'b1; mode = m + 2'd1; seed = s ^ 16'hFFFF;   // start while busy
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 20000) begin
            @(negedge clk); n++;
        end
        chk("run_completes", 128'(done), 128'(1));
        repeat (3) @(negedge clk);
    endtask

    initial begin : driver
        int fl;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 128'(outs_all), 128'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outputs", 128'(outs_all), 128'(0));

        run(2'd0, 16'hABCD, -1, -1, 1'b0, 1'b0);
        run(2'd1, 16'h5A5A, -1, -1, 1'b0, 1'b0);
        run(2'd2, 16'h0000, -1, -1, 1'b0, 1'b0);
        run(2'd0, 16'h0000,  5, -1, 1'b0, 1'b0);
        run(2'd0, 16'(($urandom)), -1, 3, 1'b0, 1'b0);
        run(2'd3, 16'h0F0F, -1, -1, 1'b0, 1'b1);
        run(2'd3, 16'h1234, -1, -1, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            fl = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NW - 1)) : -1;
            run(2'($urandom_range(0, 3)), 16'($urandom), fl, -1, 1'b1, 1'b0);
        end

        chk("wr_queue_drained",  128'(exp_wr.size()), 128'(0));
        chk("rd_queue_drained",  128'(exp_rd.size()), 128'(0));
        chk("res_queue_drained", 128'(exp_res.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
